// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line-level constants,
// common to the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path. The head entry is visible
// combinationally on rdata. A push while full is dropped, even if a pop
// happens on the same edge.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit tells full apart from empty.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty   = (wptr_q == rptr_q);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    rdata   = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: FIFO-buffered bytes serialised as start/8 data/stop
// frames at OVERSAMPLE clocks per bit. Define UART_TX_PARITY_EN for even parity.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      sampleclk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] TX_DATA,
  input  logic                      TX_EN,
  output logic                      TX_STATUS,
  output logic                      TX_BUSY,
  output logic                      UART_TX
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);

  uart_state_e               state_q;
  logic                      tx_q;
  logic [TW-1:0]             tick_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      tick_end;
  logic [TW-1:0]             tick_nxt;
  logic                      last_stop;
  logic                      pop;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sampleclk),
    .rst   (reset),
    .push  (TX_EN),
    .pop   (pop),
    .wdata (TX_DATA),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Popping on the final stop tick chains frames with no idle gap.
  always_comb begin
    tick_end  = (tick_q == TW'(OVERSAMPLE - 1));
    tick_nxt  = tick_end ? '0 : tick_q + TW'(1);
    last_stop = (state_q == STOP) && tick_end && (bit_q == 3'(STOP_BITS - 1));
    pop       = !fifo_empty && ((state_q == IDLE) || last_stop);
  end

  always_ff @(posedge sampleclk) begin
    if (reset) begin
      state_q  <= IDLE;
      tx_q     <= UART_IDLE_LEVEL;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= UART_IDLE_LEVEL;
          if (pop) begin
            state_q  <= START;
            tx_q     <= ~UART_IDLE_LEVEL;
            tick_q   <= '0;
            shift_q  <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^fifo_rdata;
`endif
          end
        end
        START: begin
          tick_q <= tick_nxt;
          if (tick_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          tick_q <= tick_nxt;
          if (tick_end) begin
            if (bit_q == 3'(UART_DATA_BITS - 1)) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tick_q <= tick_nxt;
          if (tick_end) begin
            state_q <= STOP;
            bit_q   <= '0;
            tx_q    <= UART_IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          tick_q <= tick_nxt;
          if (last_stop) begin
            bit_q <= '0;
            if (pop) begin
              state_q  <= START;
              tx_q     <= ~UART_IDLE_LEVEL;
              shift_q  <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^fifo_rdata;
`endif
            end else begin
              state_q <= IDLE;
            end
          end else if (tick_end) begin
            bit_q <= bit_q + 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

  assign UART_TX   = tx_q;
  assign TX_STATUS = ~fifo_full;
  assign TX_BUSY   = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: exact frame timing, back-to-back
// chaining, FIFO overflow, mid-frame reset and a receiver-model loopback.
module tb_uart_transmitter;

  localparam int unsigned OS    = 16;
  localparam int unsigned STOPB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PARB  = 1;
`else
  localparam int unsigned PARB  = 0;
`endif
  localparam int unsigned NBITS = 10 + STOPB - 1 + PARB;
  localparam int unsigned FRAME = OS * NBITS;

  logic       sampleclk;
  logic       reset;
  logic [7:0] TX_DATA;
  logic       TX_EN;
  logic       TX_STATUS;
  logic       TX_BUSY;
  logic       UART_TX;

  int unsigned vectors;
  int unsigned miscompares;

  logic [7:0]  rxq[$];
  logic        mon_en;
  int unsigned rx_ferr;
  int unsigned rx_perr;

  uart_transmitter #(
    .OVERSAMPLE (OS),
    .STOP_BITS  (STOPB),
    .FIFO_DEPTH (4)
  ) dut (
    .sampleclk (sampleclk),
    .reset     (reset),
    .TX_DATA   (TX_DATA),
    .TX_EN     (TX_EN),
    .TX_STATUS (TX_STATUS),
    .TX_BUSY   (TX_BUSY),
    .UART_TX   (UART_TX)
  );

  initial sampleclk = 1'b0;
  always #5 sampleclk = ~sampleclk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot idx of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PARB == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Caller is positioned on the first sample of the frame; returns on the
  // first sample after it.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    int unsigned good;
    int unsigned busy;
    busy = 0;
    for (int unsigned bi = 0; bi < NBITS; bi++) begin
      good = 0;
      for (int unsigned k = 0; k < OS; k++) begin
        if (UART_TX === frame_bit(b, bi)) good++;
        if (TX_BUSY === 1'b1) busy++;
        TX_EN = 1'b0;
        @(negedge sampleclk);
      end
      chk($sformatf("%s bit%0d", tag, bi), good, OS);
    end
    chk($sformatf("%s busy_cycles", tag), busy, FRAME);
  endtask

  task automatic wait_q(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned t;
    t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge sampleclk);
      t++;
    end
    chk($sformatf("%s rx_count", tag), rxq.size(), n);
  endtask

  // Receiver model: detect start, sample mid-bit, check parity/stop.
  initial begin : monitor
    logic [7:0] d;
    forever begin
      @(negedge sampleclk);
      if (UART_TX === 1'b0 && reset === 1'b0) begin
        repeat (OS / 2) @(negedge sampleclk);
        if (UART_TX !== 1'b0) continue;
        for (int i = 0; i < 8; i++) begin
          repeat (OS) @(negedge sampleclk);
          d[i] = UART_TX;
        end
`ifdef UART_TX_PARITY_EN
        repeat (OS) @(negedge sampleclk);
        if (UART_TX !== ^d && mon_en) rx_perr++;
`endif
        repeat (OS) @(negedge sampleclk);
        if (UART_TX !== 1'b1 && mon_en) rx_ferr++;
        if (mon_en) rxq.push_back(d);
      end
    end
  end

  initial begin : stimulus
    int unsigned lows;
    logic [7:0]  lb [4];
    vectors     = 0;
    miscompares = 0;
    rx_ferr     = 0;
    rx_perr     = 0;
    mon_en      = 1'b1;
    reset       = 1'b1;
    TX_EN       = 1'b0;
    TX_DATA     = 8'h00;

    // Reset values
    repeat (3) @(negedge sampleclk);
    chk("reset UART_TX", UART_TX, 1'b1);
    chk("reset TX_STATUS", TX_STATUS, 1'b1);
    chk("reset TX_BUSY", TX_BUSY, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge sampleclk);
    chk("idle UART_TX", UART_TX, 1'b1);

    // Single byte 0x55: line falls one cycle after the write edge
    TX_EN = 1'b1; TX_DATA = 8'h55;
    @(negedge sampleclk);
    TX_EN = 1'b0; TX_DATA = 8'hxx;
    chk("b55 line_before_start", UART_TX, 1'b1);
    chk("b55 busy_after_write", TX_BUSY, 1'b1);
    @(negedge sampleclk);
    expect_frame(8'h55, "b55");
    chk("b55 busy_end", TX_BUSY, 1'b0);
    chk("b55 line_end", UART_TX, 1'b1);
    repeat (5) @(negedge sampleclk);

    // Byte 0x07: parity bit 1 when enabled; frame length follows the build
    TX_EN = 1'b1; TX_DATA = 8'h07;
    @(negedge sampleclk);
    TX_EN = 1'b0;
    @(negedge sampleclk);
    expect_frame(8'h07, "b07");
    chk("b07 busy_end", TX_BUSY, 1'b0);
    repeat (5) @(negedge sampleclk);

    // Back-to-back 0xA5, 0x3C with no idle gap between frames
    TX_EN = 1'b1; TX_DATA = 8'hA5;
    @(negedge sampleclk);
    TX_DATA = 8'h3C;
    @(negedge sampleclk);
    TX_EN = 1'b0;
    expect_frame(8'hA5, "bA5");
    expect_frame(8'h3C, "b3C");
    chk("b2b busy_end", TX_BUSY, 1'b0);
    chk("b2b line_end", UART_TX, 1'b1);
    repeat (5) @(negedge sampleclk);

    // Overflow: six consecutive writes, the sixth is dropped
    rxq.delete();
    TX_EN = 1'b1; TX_DATA = 8'h01;
    @(negedge sampleclk); TX_DATA = 8'h02;
    @(negedge sampleclk); TX_DATA = 8'h03;
    @(negedge sampleclk); TX_DATA = 8'h04;
    @(negedge sampleclk); TX_DATA = 8'h05;
    chk("ovf status_before_5th", TX_STATUS, 1'b1);
    @(negedge sampleclk); TX_DATA = 8'h06;
    chk("ovf status_full", TX_STATUS, 1'b0);
    @(negedge sampleclk);
    TX_EN = 1'b0;
    chk("ovf status_still_full", TX_STATUS, 1'b0);
    wait_q(5, 5 * FRAME + 100, "ovf");
    repeat (FRAME + 50) @(negedge sampleclk);
    chk("ovf rx_total", rxq.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("ovf rx%0d", i), rxq[i], 8'(i + 1));
    chk("ovf busy_end", TX_BUSY, 1'b0);
    chk("ovf status_end", TX_STATUS, 1'b1);

    // Mid-frame reset: 0xFF abandoned at cycle 70, queued 0x11 flushed
    mon_en = 1'b0;
    TX_EN = 1'b1; TX_DATA = 8'hFF;
    @(negedge sampleclk);
    TX_DATA = 8'h11;
    @(negedge sampleclk);
    TX_EN = 1'b0;
    repeat (69) @(negedge sampleclk);
    chk("rst busy_mid_frame", TX_BUSY, 1'b1);
    reset = 1'b1;
    @(negedge sampleclk);
    reset = 1'b0;
    chk("rst UART_TX", UART_TX, 1'b1);
    chk("rst TX_BUSY", TX_BUSY, 1'b0);
    chk("rst TX_STATUS", TX_STATUS, 1'b1);
    lows = 0;
    repeat (2 * FRAME) begin
      @(negedge sampleclk);
      if (UART_TX !== 1'b1) lows++;
    end
    chk("rst no_frame_after", lows, 0);
    chk("rst busy_after", TX_BUSY, 1'b0);
    mon_en = 1'b1;

    // Loopback through the receiver model
    rxq.delete();
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'hC3;
    TX_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      TX_DATA = lb[i];
      @(negedge sampleclk);
    end
    TX_EN = 1'b0;
    wait_q(4, 4 * FRAME + 100, "loop");
    repeat (OS) @(negedge sampleclk);
    for (int i = 0; i < 4; i++) chk($sformatf("loop rx%0d", i), rxq[i], lb[i]);
    chk("loop framing_errors", rx_ferr, 0);
    chk("loop parity_errors", rx_perr, 0);
    chk("loop busy_end", TX_BUSY, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
